i2c_reg_file: RTL and testbench

I2C_REG_FILE -- requirements
Module: i2c_reg_file

---
 rtl/i2c_reg_pkg.sv | 47 ++++
 rtl/i2c_w0c_flag.sv | 20 ++
 rtl/i2c_reg_file.sv | 197 +++++++++++++++++++
 tb/tb_i2c_reg_file.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_reg_pkg.sv
// Shared register map, bit positions and reset values for the I2C controller register file.
package i2c_reg_pkg;

    localparam logic [7:0] OFF_ADR   = 8'h00;
    localparam logic [7:0] OFF_FDR   = 8'h04;
    localparam logic [7:0] OFF_CR    = 8'h08;
    localparam logic [7:0] OFF_SR    = 8'h0C;
    localparam logic [7:0] OFF_DR    = 8'h10;
    localparam logic [7:0] OFF_DFSRR = 8'h14;

    localparam int CR_MEN  = 7;
    localparam int CR_MIEN = 6;
    localparam int CR_MSTA = 5;
    localparam int CR_MTX  = 4;
    localparam int CR_TXAK = 3;
    localparam int CR_RSTA = 2;

    localparam int SR_MCF  = 7;
    localparam int SR_MAAS = 6;
    localparam int SR_MBB  = 5;
    localparam int SR_MAL  = 4;
    localparam int SR_SRW  = 2;
    localparam int SR_MIF  = 1;
    localparam int SR_RXAK = 0;

    // RSTA is a strobe and bits 1:0 are reserved, so only 7:3 are stored
    localparam logic [7:0] CR_STORE_MASK = 8'hF8;

    localparam logic [7:0] RST_ADR    = 8'h00;
    localparam logic [7:0] RST_FDR    = 8'h00;
    localparam logic [7:0] RST_CR     = 8'h00;
    localparam logic [7:0] RST_DFSRR  = 8'h10;
    localparam logic [7:0] RST_RXBUF  = 8'h00;
    localparam logic [7:0] RST_TXDATA = 8'h00;
    localparam logic       RST_MCF    = 1'b1;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_ADR,
        SEL_FDR,
        SEL_CR,
        SEL_SR,
        SEL_DR,
        SEL_DFSRR
    } reg_sel_e;

endpackage

// File: rtl/i2c_w0c_flag.sv
// Sticky status flag: hardware set, software write-0 clear, set wins on a collision.
module i2c_w0c_flag (
    input  logic i_sysclk,
    input  logic i_reset_n,
    input  logic i_set,
    input  logic i_clr,
    output logic o_flag
);

    always_ff @(posedge i_sysclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_flag <= 1'b0;
        end else if (i_set) begin
            o_flag <= 1'b1;
        end else if (i_clr) begin
            o_flag <= 1'b0;
        end
    end

endmodule

// File: rtl/i2c_reg_file.sv
// Host-side register file of the I2C controller: configuration registers, status flags,
// data register handshakes with the bit-level core and the interrupt output.
module i2c_reg_file
    import i2c_reg_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              i_sysclk,
    input  logic              i_reset_n,
    input  logic              i_wr_ena,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [7:0]        i_wr_data,
    input  logic              i_rd_ena,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [7:0]        o_rd_data,
    output logic [7:0]        o_adr,
    output logic [7:0]        o_fdr,
    output logic [7:0]        o_dfsrr,
    output logic [7:0]        o_cr,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_start,
    output logic              o_rx_taken,
    output logic              o_rsta,
    output logic              o_irq,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    input  logic              i_xfer_done,
    input  logic              i_arb_lost,
    input  logic              i_bus_busy,
    input  logic              i_maas,
    input  logic              i_srw,
    input  logic              i_rxak
);

    function automatic reg_sel_e decode(input logic [ADDR_W-1:0] addr);
        if (addr == ADDR_W'(OFF_ADR))   return SEL_ADR;
        if (addr == ADDR_W'(OFF_FDR))   return SEL_FDR;
        if (addr == ADDR_W'(OFF_CR))    return SEL_CR;
        if (addr == ADDR_W'(OFF_SR))    return SEL_SR;
        if (addr == ADDR_W'(OFF_DR))    return SEL_DR;
        if (addr == ADDR_W'(OFF_DFSRR)) return SEL_DFSRR;
        return SEL_NONE;
    endfunction

    reg_sel_e   wr_sel;
    reg_sel_e   rd_sel;
    logic [7:0] adr;
    logic [7:0] fdr;
    logic [7:0] dfsrr;
    logic [7:0] cr;
    logic [7:0] rx_buf;
    logic [7:0] sr;
    logic [7:0] rd_mux;
    logic       men;
    logic       mcf;
    logic       mif;
    logic       mal;
    logic       cr_disable;
    logic       dr_write;
    logic       dr_read;
    logic       mif_clr;
    logic       mal_clr;

    assign wr_sel = i_wr_ena ? decode(i_wr_addr) : SEL_NONE;
    assign rd_sel = i_rd_ena ? decode(i_rd_addr) : SEL_NONE;

    // DR traffic is gated by the currently stored enable, not by a CR write in flight
    assign men        = cr[CR_MEN];
    assign cr_disable = (wr_sel == SEL_CR) && !i_wr_data[CR_MEN];
    assign dr_write   = (wr_sel == SEL_DR) && men;
    assign dr_read    = (rd_sel == SEL_DR) && men;

    assign mif_clr = ((wr_sel == SEL_SR) && !i_wr_data[SR_MIF]) || cr_disable;
    assign mal_clr = ((wr_sel == SEL_SR) && !i_wr_data[SR_MAL]) || cr_disable;

    i2c_w0c_flag u_mif (
        .i_sysclk  (i_sysclk),
        .i_reset_n (i_reset_n),
        .i_set     (i_xfer_done | i_arb_lost),
        .i_clr     (mif_clr),
        .o_flag    (mif)
    );

    i2c_w0c_flag u_mal (
        .i_sysclk  (i_sysclk),
        .i_reset_n (i_reset_n),
        .i_set     (i_arb_lost),
        .i_clr     (mal_clr),
        .o_flag    (mal)
    );

    always_ff @(posedge i_sysclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            adr   <= RST_ADR;
            fdr   <= RST_FDR;
            dfsrr <= RST_DFSRR;
        end else begin
            case (wr_sel)
                SEL_ADR:   adr   <= i_wr_data;
                SEL_FDR:   fdr   <= i_wr_data;
                SEL_DFSRR: dfsrr <= i_wr_data;
                default:   ;
            endcase
        end
    end

    // Arbitration loss is applied last so it overrides a concurrent software MSTA write
    always_ff @(posedge i_sysclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cr <= RST_CR;
        end else begin
            if (wr_sel == SEL_CR) begin
                cr <= i_wr_data & CR_STORE_MASK;
                if (!i_wr_data[CR_MEN]) begin
                    cr[CR_MSTA] <= 1'b0;
                end
            end
            if (i_arb_lost) begin
                cr[CR_MSTA] <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_sysclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            mcf <= RST_MCF;
        end else begin
            if (o_tx_start || o_rx_taken || cr_disable) begin
                mcf <= 1'b0;
            end
            if (i_xfer_done) begin
                mcf <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_sysclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_tx_data  <= RST_TXDATA;
            rx_buf     <= RST_RXBUF;
            o_tx_start <= 1'b0;
            o_rx_taken <= 1'b0;
            o_rsta     <= 1'b0;
            o_irq      <= 1'b0;
        end else begin
            if (dr_write) begin
                o_tx_data <= i_wr_data;
            end
            if (i_rx_valid) begin
                rx_buf <= i_rx_data;
            end
            o_tx_start <= dr_write;
            o_rx_taken <= dr_read;
            o_rsta     <= (wr_sel == SEL_CR) && i_wr_data[CR_RSTA] && i_wr_data[CR_MEN];
            o_irq      <= mif && cr[CR_MIEN];
        end
    end

    always_comb begin
        sr          = 8'h00;
        sr[SR_MCF]  = mcf;
        sr[SR_MAAS] = i_maas;
        sr[SR_MBB]  = i_bus_busy;
        sr[SR_MAL]  = mal;
        sr[SR_SRW]  = i_srw;
        sr[SR_MIF]  = mif;
        sr[SR_RXAK] = i_rxak;
    end

    always_comb begin
        rd_mux = 8'h00;
        case (rd_sel)
            SEL_ADR:   rd_mux = adr;
            SEL_FDR:   rd_mux = fdr;
            SEL_CR:    rd_mux = cr;
            SEL_SR:    rd_mux = sr;
            SEL_DR:    rd_mux = men ? rx_buf : 8'h00;
            SEL_DFSRR: rd_mux = dfsrr;
            default:   rd_mux = 8'h00;
        endcase
    end

    // Read data reflects register contents before any same-edge write
    always_ff @(posedge i_sysclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_rd_data <= 8'h00;
        end else if (i_rd_ena) begin
            o_rd_data <= rd_mux;
        end
    end

    assign o_adr   = adr;
    assign o_fdr   = fdr;
    assign o_dfsrr = dfsrr;
    assign o_cr    = cr;

endmodule

// File: tb/tb_i2c_reg_file.sv
// Scoreboard bench for i2c_reg_file: reads push expected data, a monitor pops and compares.
module tb_i2c_reg_file;

    logic       i_sysclk = 1'b0;
    logic       i_reset_n = 1'b0;
    logic       i_wr_ena = 1'b0;
    logic [5:0] i_wr_addr = '0;
    logic [7:0] i_wr_data = '0;
    logic       i_rd_ena = 1'b0;
    logic [5:0] i_rd_addr = '0;
    logic [7:0] o_rd_data;
    logic [7:0] o_adr;
    logic [7:0] o_fdr;
    logic [7:0] o_dfsrr;
    logic [7:0] o_cr;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic       o_rx_taken;
    logic       o_rsta;
    logic       o_irq;
    logic [7:0] i_rx_data = '0;
    logic       i_rx_valid = 1'b0;
    logic       i_xfer_done = 1'b0;
    logic       i_arb_lost = 1'b0;
    logic       i_bus_busy = 1'b0;
    logic       i_maas = 1'b0;
    logic       i_srw = 1'b0;
    logic       i_rxak = 1'b1;

    i2c_reg_file #(.ADDR_W(6)) dut (
        .i_sysclk    (i_sysclk),
        .i_reset_n   (i_reset_n),
        .i_wr_ena    (i_wr_ena),
        .i_wr_addr   (i_wr_addr),
        .i_wr_data   (i_wr_data),
        .i_rd_ena    (i_rd_ena),
        .i_rd_addr   (i_rd_addr),
        .o_rd_data   (o_rd_data),
        .o_adr       (o_adr),
        .o_fdr       (o_fdr),
        .o_dfsrr     (o_dfsrr),
        .o_cr        (o_cr),
        .o_tx_data   (o_tx_data),
        .o_tx_start  (o_tx_start),
        .o_rx_taken  (o_rx_taken),
        .o_rsta      (o_rsta),
        .o_irq       (o_irq),
        .i_rx_data   (i_rx_data),
        .i_rx_valid  (i_rx_valid),
        .i_xfer_done (i_xfer_done),
        .i_arb_lost  (i_arb_lost),
        .i_bus_busy  (i_bus_busy),
        .i_maas      (i_maas),
        .i_srw       (i_srw),
        .i_rxak      (i_rxak)
    );

    always #5 i_sysclk = ~i_sysclk;

    typedef struct {
        logic       wr;
        logic [5:0] wa;
        logic [7:0] wd;
        logic       rd;
        logic [5:0] ra;
        logic [7:0] rexp;
        logic       xfer;
        logic       arb;
        logic       rxv;
        logic [7:0] rxd;
    } stim_t;

    typedef struct {
        logic [5:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   failures = 0;
    int   rsta_cnt = 0;
    int   tx_start_cnt = 0;
    int   rx_taken_cnt = 0;
    logic rd_seen = 1'b0;
    int   base_a;
    int   base_b;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{wr: 1'b0, wa: 6'h0, wd: 8'h0, rd: 1'b0, ra: 6'h0, rexp: 8'h0,
              xfer: 1'b0, arb: 1'b0, rxv: 1'b0, rxd: 8'h0};
        return s;
    endfunction

    function automatic stim_t mk_wr(input logic [5:0] a, input logic [7:0] d);
        stim_t s = idle();
        s.wr = 1'b1;
        s.wa = a;
        s.wd = d;
        return s;
    endfunction

    function automatic stim_t mk_rd(input logic [5:0] a, input logic [7:0] e);
        stim_t s = idle();
        s.rd   = 1'b1;
        s.ra   = a;
        s.rexp = e;
        return s;
    endfunction

    // One vector per clock: driven on the falling edge, sampled on the next rising edge
    task automatic applyStimulus(input stim_t s);
        exp_t e;
        @(negedge i_sysclk);
        i_wr_ena    = s.wr;
        i_wr_addr   = s.wa;
        i_wr_data   = s.wd;
        i_rd_ena    = s.rd;
        i_rd_addr   = s.ra;
        i_xfer_done = s.xfer;
        i_arb_lost  = s.arb;
        i_rx_valid  = s.rxv;
        i_rx_data   = s.rxd;
        if (s.rd) begin
            e.addr = s.ra;
            e.data = s.rexp;
            exp_q.push_back(e);
        end
    endtask

    always @(posedge i_sysclk) rd_seen <= i_rd_ena;

    always @(negedge i_sysclk) begin
        if (rd_seen) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                failures++;
                $display("[TB] FAIL scoreboard: read data with no expectation, got 0x%0h", o_rd_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput($sformatf("rd_0x%02h", e.addr), {24'h0, o_rd_data}, {24'h0, e.data});
            end
        end
        if (o_rsta)     rsta_cnt++;
        if (o_tx_start) tx_start_cnt++;
        if (o_rx_taken) rx_taken_cnt++;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        stim_t s;
        repeat (3) @(negedge i_sysclk);
        checkOutput("rst_rd_data", o_rd_data, 8'h00);
        checkOutput("rst_dfsrr", o_dfsrr, 8'h10);
        checkOutput("rst_cr", o_cr, 8'h00);
        checkOutput("rst_tx_data", o_tx_data, 8'h00);
        checkOutput("rst_pulses", {o_tx_start, o_rx_taken, o_rsta, o_irq}, 4'b0000);
        i_reset_n = 1'b1;

        applyStimulus(mk_rd(6'h00, 8'h00));
        applyStimulus(mk_rd(6'h04, 8'h00));
        applyStimulus(mk_rd(6'h08, 8'h00));
        applyStimulus(mk_rd(6'h0C, 8'h81));
        applyStimulus(mk_rd(6'h10, 8'h00));
        applyStimulus(mk_rd(6'h14, 8'h10));
        applyStimulus(idle());

        // same-cycle read and write returns the old value
        s = mk_wr(6'h00, 8'h5A);
        s.rd = 1'b1; s.ra = 6'h00; s.rexp = 8'h00;
        applyStimulus(s);
        applyStimulus(mk_rd(6'h00, 8'h5A));
        applyStimulus(mk_wr(6'h04, 8'h3C));
        applyStimulus(mk_wr(6'h14, 8'h20));
        applyStimulus(mk_rd(6'h04, 8'h3C));
        applyStimulus(mk_rd(6'h14, 8'h20));
        applyStimulus(idle());

        base_a = rsta_cnt;
        applyStimulus(mk_wr(6'h08, 8'hF4));
        applyStimulus(idle());
        applyStimulus(idle());
        checkOutput("rsta_pulse_count", rsta_cnt - base_a, 1);
        checkOutput("cr_value", o_cr, 8'hF0);
        applyStimulus(mk_rd(6'h08, 8'hF0));
        applyStimulus(idle());

        base_a = tx_start_cnt;
        applyStimulus(mk_wr(6'h10, 8'hA5));
        applyStimulus(idle());
        applyStimulus(idle());
        checkOutput("tx_data", o_tx_data, 8'hA5);
        checkOutput("tx_start_count", tx_start_cnt - base_a, 1);
        applyStimulus(mk_rd(6'h0C, 8'h01));
        s = idle(); s.xfer = 1'b1;
        applyStimulus(s);
        applyStimulus(idle());
        applyStimulus(idle());
        checkOutput("irq_after_xfer", o_irq, 1'b1);
        i_bus_busy = 1'b1;
        i_maas     = 1'b1;
        applyStimulus(mk_rd(6'h0C, 8'hE3));
        applyStimulus(idle());
        i_bus_busy = 1'b0;
        i_maas     = 1'b0;

        s = mk_wr(6'h08, 8'hE0); s.arb = 1'b1;
        applyStimulus(s);
        applyStimulus(mk_rd(6'h08, 8'hC0));
        applyStimulus(mk_rd(6'h0C, 8'h93));
        applyStimulus(mk_wr(6'h0C, 8'h12));
        applyStimulus(mk_rd(6'h0C, 8'h93));
        s = mk_wr(6'h0C, 8'h00); s.xfer = 1'b1;
        applyStimulus(s);
        applyStimulus(mk_rd(6'h0C, 8'h83));
        applyStimulus(mk_wr(6'h0C, 8'h00));
        applyStimulus(idle());
        applyStimulus(idle());
        checkOutput("irq_after_clear", o_irq, 1'b0);
        applyStimulus(mk_rd(6'h0C, 8'h81));

        base_a = rx_taken_cnt;
        s = idle(); s.rxv = 1'b1; s.rxd = 8'h3C;
        applyStimulus(s);
        applyStimulus(mk_rd(6'h10, 8'h3C));
        applyStimulus(idle());
        applyStimulus(idle());
        checkOutput("rx_taken_count", rx_taken_cnt - base_a, 1);
        applyStimulus(mk_rd(6'h0C, 8'h01));

        s = mk_wr(6'h20, 8'h55);
        s.rd = 1'b1; s.ra = 6'h3F; s.rexp = 8'h00;
        applyStimulus(s);
        applyStimulus(idle());
        checkOutput("unmapped_regs", {o_adr, o_fdr, o_cr, o_dfsrr}, 32'h5A3CC020);
        checkOutput("unmapped_tx", o_tx_data, 8'hA5);

        // disabling the core clears MCF/MIF even after a completed transfer
        s = idle(); s.xfer = 1'b1;
        applyStimulus(s);
        applyStimulus(mk_wr(6'h08, 8'h00));
        applyStimulus(mk_rd(6'h0C, 8'h01));
        base_a = tx_start_cnt;
        base_b = rx_taken_cnt;
        applyStimulus(mk_wr(6'h10, 8'h77));
        applyStimulus(mk_rd(6'h10, 8'h00));
        applyStimulus(idle());
        applyStimulus(idle());
        checkOutput("men0_tx_start", tx_start_cnt - base_a, 0);
        checkOutput("men0_rx_taken", rx_taken_cnt - base_b, 0);
        checkOutput("men0_tx_data", o_tx_data, 8'hA5);
        checkOutput("men0_irq", o_irq, 1'b0);
        base_a = rsta_cnt;
        applyStimulus(mk_wr(6'h08, 8'h04));
        applyStimulus(idle());
        applyStimulus(idle());
        checkOutput("men0_rsta", rsta_cnt - base_a, 0);

        // reset while a tx_start pulse is in flight
        applyStimulus(mk_wr(6'h08, 8'h80));
        base_a = tx_start_cnt;
        applyStimulus(mk_wr(6'h10, 8'h11));
        @(posedge i_sysclk);
        #1;
        i_reset_n = 1'b0;
        i_wr_ena  = 1'b0;
        i_rd_ena  = 1'b0;
        repeat (2) @(negedge i_sysclk);
        i_reset_n = 1'b1;
        repeat (3) applyStimulus(idle());
        checkOutput("midreset_tx_start", tx_start_cnt - base_a, 0);
        checkOutput("midreset_regs", {o_cr, o_tx_data, o_dfsrr}, 24'h000010);
        applyStimulus(mk_rd(6'h0C, 8'h81));
        applyStimulus(mk_rd(6'h00, 8'h00));
        applyStimulus(idle());
        applyStimulus(idle());
        checkOutput("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
